id_stage: RTL and testbench

- Instruction-decode stage of the 5-stage MIPS pipeline; the consumer of the 64-bit IF_ID register ({PC_Plus4, Instruction}).
- Resolves branches, jumps and jr/jalr in ID, and drives the fetch controls PCSrc, the three target addresses, IF_Flush and IF_Pause.
- Detects load-use and branch-operand hazards; accepts interrupts and undefined-opcode exceptions.
- Registers the decoded instruction into ID_EX.

---
 rtl/id_stage.sv | 168 ++++++++++++++++
 tb/tb_id_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction-decode stage: branch/jump resolution, hazard stalls, interrupt/exception entry, ID_EX register.
// Optional build macro ID_BRANCH_FWD_EN enables MEM->ID operand forwarding.
module id_stage #(
    parameter int unsigned IRQ_VEC_MODE = 0
) (
    input  logic         clk,
    input  logic         reset_b,
    input  logic [63:0]  IF_ID,
    input  logic [31:0]  rs_data,
    input  logic [31:0]  rt_data,
    input  logic         ex_reg_write,
    input  logic         ex_mem_read,
    input  logic [4:0]   ex_rd,
    input  logic         mem_reg_write,
    input  logic [4:0]   mem_rd,
    input  logic [31:0]  mem_result,
    input  logic         irq,
    output logic [4:0]   rs_addr,
    output logic [4:0]   rt_addr,
    output logic [2:0]   PCSrc,
    output logic [31:0]  branch_address,
    output logic [31:0]  jump_address,
    output logic [31:0]  jr_address,
    output logic         IF_Flush,
    output logic         IF_Pause,
    output logic         intruption,
    output logic         exception,
    output logic [31:0]  epc,
    output logic [159:0] ID_EX
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned CNTW = 2;

    logic [XLEN-1:0] w_pc4, w_instr, w_rs_val, w_rt_val, w_imm_ext, w_boff;
    logic [5:0]      w_op;
    logic [4:0]      w_rs, w_rt;
    logic            w_kernel, w_is_b, w_is_j, w_is_jr, w_legal, w_taken;
    logic            w_ex_hit, w_mem_hit, w_stall, w_intr, w_exc;
    logic [CNTW-1:0] w_need, w_stall_cnt_nxt;
    logic [2:0]      w_pcsrc;
    logic [159:0]    w_id_ex_nxt;

    logic [CNTW-1:0] r_stall_cnt;
    logic            r_flush_d, r_intr_q, r_exc_q;

    assign w_pc4    = IF_ID[63:32];
    assign w_instr  = IF_ID[31:0];
    assign w_kernel = IF_ID[63];
    assign w_op     = w_instr[31:26];
    assign w_rs     = w_instr[25:21];
    assign w_rt     = w_instr[20:16];
    assign rs_addr  = w_rs;
    assign rt_addr  = w_rt;

    // Opcode classification
    always_comb begin
        w_is_b  = 1'b0;
        w_is_j  = 1'b0;
        w_is_jr = 1'b0;
        w_legal = 1'b1;
        case (w_op)
            6'h00: w_is_jr = (w_instr[5:0] == 6'h08) || (w_instr[5:0] == 6'h09);
            6'h01: w_is_b  = (w_rt == 5'd0);
            6'h02, 6'h03: w_is_j = 1'b1;
            6'h04, 6'h05, 6'h06, 6'h07: w_is_b = 1'b1;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

`ifdef ID_BRANCH_FWD_EN
    assign w_rs_val = (mem_reg_write && mem_rd != 5'd0 && mem_rd == w_rs) ? mem_result : rs_data;
    assign w_rt_val = (mem_reg_write && mem_rd != 5'd0 && mem_rd == w_rt) ? mem_result : rt_data;
`else
    logic w_unused_mem_result;
    assign w_unused_mem_result = ^mem_result;
    assign w_rs_val = rs_data;
    assign w_rt_val = rt_data;
`endif

    assign w_ex_hit  = (w_rs != 5'd0 && ex_rd == w_rs) || (w_rt != 5'd0 && ex_rd == w_rt);
    assign w_mem_hit = (w_rs != 5'd0 && mem_rd == w_rs) || (w_rt != 5'd0 && mem_rd == w_rt);

    // Stall length demanded by the instruction now in ID
    always_comb begin
        w_need = CNTW'(0);
`ifdef ID_BRANCH_FWD_EN
        if ((w_is_b || w_is_jr) && w_ex_hit && ex_mem_read)
            w_need = CNTW'(2);
        else if ((w_is_b || w_is_jr) && w_ex_hit && ex_reg_write)
            w_need = CNTW'(1);
        else if (ex_mem_read && w_ex_hit)
            w_need = CNTW'(1);
`else
        if ((w_is_b || w_is_jr) && w_ex_hit && (ex_reg_write || ex_mem_read))
            w_need = CNTW'(2);
        else if ((w_is_b || w_is_jr) && w_mem_hit && mem_reg_write)
            w_need = CNTW'(1);
        else if (ex_mem_read && w_ex_hit)
            w_need = CNTW'(1);
`endif
    end

    // Counter holds the stall cycles remaining after the detection cycle
    always_comb begin
        w_stall_cnt_nxt = r_stall_cnt;
        if (r_stall_cnt != CNTW'(0))
            w_stall_cnt_nxt = r_stall_cnt - CNTW'(1);
        else if (w_need != CNTW'(0))
            w_stall_cnt_nxt = w_need - CNTW'(1);
    end

    assign w_stall = (r_stall_cnt != CNTW'(0)) || (w_need != CNTW'(0));

    always_comb begin
        w_taken = 1'b0;
        case (w_op)
            6'h04:   w_taken = (w_rs_val == w_rt_val);
            6'h05:   w_taken = (w_rs_val != w_rt_val);
            6'h06:   w_taken = w_rs_val[31] || (w_rs_val == 32'd0);
            6'h07:   w_taken = !w_rs_val[31] && (w_rs_val != 32'd0);
            6'h01:   w_taken = w_rs_val[31];
            default: w_taken = 1'b0;
        endcase
    end

    assign w_imm_ext = (w_op == 6'h0C || w_op == 6'h0D) ? {16'd0, w_instr[15:0]}
                                                       : {{16{w_instr[15]}}, w_instr[15:0]};
    assign w_boff    = {w_imm_ext[29:0], 2'b00};

    assign branch_address = {w_pc4[31], w_pc4[30:0] + w_boff[30:0]};
    assign jump_address   = {w_pc4[31:28], w_instr[25:0], 2'b00};
    assign jr_address     = w_rs_val;

    // Priority: stall > interrupt > exception > branch/jump
    assign w_intr   = irq && !w_kernel && !w_stall && !r_flush_d;
    assign w_exc    = !w_legal && !w_kernel && !w_stall && !w_intr;
    assign w_pcsrc  = (w_stall || w_intr || w_exc) ? 3'b000 : {w_is_jr, w_is_j, w_is_b && w_taken};

    assign PCSrc      = w_pcsrc;
    assign IF_Pause   = w_stall;
    assign IF_Flush   = !w_stall && (w_intr || w_exc || (w_pcsrc != 3'b000));
    assign intruption = w_intr || r_intr_q;
    assign exception  = w_exc || r_exc_q;

    // Bubble on stall, trap, or undefined opcode (kernel-mode nop)
    assign w_id_ex_nxt = (w_stall || w_intr || w_exc || !w_legal) ? 160'd0
                         : {w_pc4, w_rs_val, w_rt_val, w_imm_ext, w_instr};

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_stall_cnt <= CNTW'(0);
            r_flush_d   <= 1'b0;
            r_intr_q    <= 1'b0;
            r_exc_q     <= 1'b0;
            epc         <= 32'd0;
            ID_EX       <= 160'd0;
        end else begin
            r_stall_cnt <= w_stall_cnt_nxt;
            r_flush_d   <= IF_Flush;
            r_intr_q    <= (IRQ_VEC_MODE != 0) && w_intr;
            r_exc_q     <= (IRQ_VEC_MODE != 0) && w_exc;
            ID_EX       <= w_id_ex_nxt;
            if (w_intr || w_exc)
                epc <= w_pc4 - 32'd4;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage; expectations follow ID_BRANCH_FWD_EN when defined.
module tb_id_stage;
    logic         clk = 1'b0;
    logic         reset_b;
    logic [63:0]  IF_ID;
    logic [31:0]  rs_data, rt_data, mem_result;
    logic         ex_reg_write, ex_mem_read, mem_reg_write, irq;
    logic [4:0]   ex_rd, mem_rd, rs_addr, rt_addr;
    logic [2:0]   PCSrc;
    logic [31:0]  branch_address, jump_address, jr_address, epc;
    logic         IF_Flush, IF_Pause, intruption, exception;
    logic [159:0] ID_EX;

    int n_assert = 0;
    int n_fail   = 0;

    id_stage dut (
        .clk(clk), .reset_b(reset_b), .IF_ID(IF_ID), .rs_data(rs_data), .rt_data(rt_data),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result), .irq(irq),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .PCSrc(PCSrc), .branch_address(branch_address),
        .jump_address(jump_address), .jr_address(jr_address), .IF_Flush(IF_Flush),
        .IF_Pause(IF_Pause), .intruption(intruption), .exception(exception), .epc(epc),
        .ID_EX(ID_EX)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_hz(input logic exw, input logic exr, input logic [4:0] exd,
                          input logic mw, input logic [4:0] md, input logic [31:0] mres);
        ex_reg_write  = exw;
        ex_mem_read   = exr;
        ex_rd         = exd;
        mem_reg_write = mw;
        mem_rd        = md;
        mem_result    = mres;
    endtask

    initial begin
        reset_b = 1'b0; IF_ID = 64'd0; rs_data = 32'd0; rt_data = 32'd0; irq = 1'b0;
        set_hz(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        #12;
        chk("rst_idex", ID_EX, 160'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_pcsrc", PCSrc, 3'b000);
        chk("rst_flush", IF_Flush, 1'b0);
        chk("rst_pause", IF_Pause, 1'b0);
        chk("rst_badr", branch_address, 32'd0);
        chk("rst_jadr", jump_address, 32'd0);
        chk("rst_jr", jr_address, 32'd0);
        reset_b = 1'b1;
        tick;

        // beq $1,$1,+3 taken
        IF_ID = {32'h0000_0008, 32'h1021_0003}; rs_data = 32'd5; rt_data = 32'd5; #1;
        chk("beq_pcsrc", PCSrc, 3'b001);
        chk("beq_badr", branch_address, 32'h0000_0014);
        chk("beq_flush", IF_Flush, 1'b1);
        chk("beq_pause", IF_Pause, 1'b0);
        chk("beq_rsaddr", rs_addr, 5'd1);
        chk("beq_jadr", jump_address, 32'h0084_000C);
        tick;
        chk("beq_idex", ID_EX, {32'h8, 32'd5, 32'd5, 32'd3, 32'h1021_0003});

        // bne $1,$1 not taken
        IF_ID = {32'h0000_0008, 32'h1421_0003}; #1;
        chk("bne_nt_pcsrc", PCSrc, 3'b000);
        chk("bne_nt_flush", IF_Flush, 1'b0);
        tick;

        // bne $1,$2,-1 taken
        IF_ID = {32'h0000_0100, 32'h1422_FFFF}; rs_data = 32'd5; rt_data = 32'd6; #1;
        chk("bne_pcsrc", PCSrc, 3'b001);
        chk("bne_badr", branch_address, 32'h0000_00FC);
        tick;
        chk("bne_imm", ID_EX[63:32], 32'hFFFF_FFFF);

        // j
        IF_ID = {32'h3000_0010, 32'h0800_0040}; #1;
        chk("j_pcsrc", PCSrc, 3'b010);
        chk("j_jadr", jump_address, 32'h3000_0100);
        chk("j_flush", IF_Flush, 1'b1);
        tick;

        // load-use: EX lw $2, ID add $3,$2,$4
        IF_ID = {32'h0000_0040, 32'h0044_1820}; rs_data = 32'd0; rt_data = 32'd9;
        set_hz(1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 32'd0); #1;
        chk("lu_pause", IF_Pause, 1'b1);
        chk("lu_pcsrc", PCSrc, 3'b000);
        chk("lu_flush", IF_Flush, 1'b0);
        tick;
        chk("lu_bubble", ID_EX, 160'd0);
        set_hz(1'b0, 1'b0, 5'd0, 1'b1, 5'd2, 32'h77); #1;
        chk("lu_resume", IF_Pause, 1'b0);
        tick;
`ifdef ID_BRANCH_FWD_EN
        chk("lu_idex", ID_EX, {32'h40, 32'h77, 32'd9, 32'h1820, 32'h0044_1820});
`else
        chk("lu_idex", ID_EX, {32'h40, 32'h0, 32'd9, 32'h1820, 32'h0044_1820});
`endif

        // EX lw $5, ID jr $5
        IF_ID = {32'h0000_0050, 32'h00A0_0008}; rs_data = 32'h1234;
        set_hz(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0); #1;
        chk("jr_pause0", IF_Pause, 1'b1);
        chk("jr_pcsrc0", PCSrc, 3'b000);
        tick;
        chk("jr_bubble", ID_EX, 160'd0);
        set_hz(1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hABC0); #1;
        chk("jr_pause1", IF_Pause, 1'b1);
        chk("jr_pcsrc1", PCSrc, 3'b000);
        tick;
`ifdef ID_BRANCH_FWD_EN
        chk("jr_pause2", IF_Pause, 1'b0);
        chk("jr_pcsrc2", PCSrc, 3'b100);
        chk("jr_fwd", jr_address, 32'hABC0);
`else
        chk("jr_pause2", IF_Pause, 1'b1);
        chk("jr_pcsrc2", PCSrc, 3'b000);
`endif
        tick;
        set_hz(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0); rs_data = 32'hABC0; #1;
        chk("jr_pcsrc3", PCSrc, 3'b100);
        chk("jr_adr3", jr_address, 32'hABC0);
        chk("jr_flush3", IF_Flush, 1'b1);
        tick;

        // interrupt
        IF_ID = 64'd0; rs_data = 32'd0; rt_data = 32'd0; #1;
        tick;
        IF_ID = {32'h0000_0104, 32'h2001_0005}; irq = 1'b1; #1;
        chk("irq_take", intruption, 1'b1);
        chk("irq_flush", IF_Flush, 1'b1);
        chk("irq_pcsrc", PCSrc, 3'b000);
        chk("irq_noexc", exception, 1'b0);
        tick;
        chk("irq_epc", epc, 32'h0000_0100);
        chk("irq_idex", ID_EX, 160'd0);
        chk("irq_flushd_blk", intruption, 1'b0);
        tick;
        IF_ID = {32'h8000_0104, 32'h2001_0005}; #1;
        chk("irq_kernel", intruption, 1'b0);
        chk("irq_kernel_flush", IF_Flush, 1'b0);
        tick;
        chk("irq_kernel_idex", ID_EX, {32'h8000_0104, 32'd0, 32'd0, 32'd5, 32'h2001_0005});
        chk("irq_kernel_epc", epc, 32'h0000_0100);
        irq = 1'b0;

        // undefined opcodes
        IF_ID = {32'h0000_0208, 32'hFC00_0000}; #1;
        chk("exc_3f", exception, 1'b1);
        chk("exc_flush", IF_Flush, 1'b1);
        chk("exc_nointr", intruption, 1'b0);
        tick;
        chk("exc_epc", epc, 32'h0000_0204);
        chk("exc_idex", ID_EX, 160'd0);
        IF_ID = {32'h0000_020C, 32'h3800_0000}; #1;
        chk("exc_0e", exception, 1'b1);
        tick;
        chk("exc_0e_epc", epc, 32'h0000_0208);
        IF_ID = {32'h0000_0210, 32'h3C01_0000}; #1;
        chk("legal_0f", exception, 1'b0);
        tick;
        IF_ID = 64'd0; #1;
        tick;
        IF_ID = {32'h0000_030C, 32'hFC00_0000}; irq = 1'b1; #1;
        chk("exc_irq_intr", intruption, 1'b1);
        chk("exc_irq_exc", exception, 1'b0);
        tick;
        chk("exc_irq_epc", epc, 32'h0000_0308);
        irq = 1'b0;
        IF_ID = {32'h8000_0400, 32'hFC00_0000}; #1;
        chk("kexc_none", exception, 1'b0);
        chk("kexc_flush", IF_Flush, 1'b0);
        tick;
        chk("kexc_idex", ID_EX, 160'd0);
        chk("kexc_epc", epc, 32'h0000_0308);

        // reset in the middle of a two-cycle stall
        IF_ID = {32'h0000_0050, 32'h00A0_0008}; rs_data = 32'h1234;
        set_hz(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0); #1;
        chk("rm_pause", IF_Pause, 1'b1);
        tick;
        #2;
        reset_b = 1'b0; #1;
        chk("rm_idex", ID_EX, 160'd0);
        chk("rm_epc", epc, 32'd0);
        set_hz(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        tick;
        #2;
        reset_b = 1'b1; #1;
        chk("rm_pause_rel", IF_Pause, 1'b0);
        chk("rm_pcsrc_rel", PCSrc, 3'b100);
        chk("rm_jr_rel", jr_address, 32'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
